// File: rtl/int_seq_pkg.sv
// Shared state codes, source encoding and vector constants for the
// interrupt/reset entry sequencer.
package int_seq_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] C1   = 3'd1;
  localparam logic [2:0] C2   = 3'd2;
  localparam logic [2:0] C3   = 3'd3;
  localparam logic [2:0] C4   = 3'd4;
  localparam logic [2:0] C5   = 3'd5;
  localparam logic [2:0] C6   = 3'd6;

  typedef enum logic [1:0] {
    SRC_RES = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } src_t;

  localparam logic [15:0] VEC_RES  = 16'hFFFC;
  localparam logic [15:0] VEC_NMI  = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ0 = 16'hFFFE;

  // Channel 0 keeps the legacy IRQ/BRK vector; the rest step down by 2 from base.
  function automatic logic [15:0] irq_vector(input logic [15:0] base, input logic [2:0] ch);
    if (ch == 3'd0) return VEC_IRQ0;
    return base - {12'd0, ch - 3'd1, 1'b0};
  endfunction

endpackage

// File: rtl/nmi_edge_sync.sv
// Multi-stage synchroniser for the asynchronous _NMI pin, producing a
// one-cycle pulse on each synchronised falling edge.
module nmi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_n,
  output logic nmi_fall
);

  logic [STAGES-1:0] sync_reg;
  logic              last_reg;

  // Chain idles high so a pin held inactive never looks like an edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
      last_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], nmi_n};
      last_reg <= sync_reg[STAGES-1];
    end
  end

  assign nmi_fall = last_reg & ~sync_reg[STAGES-1];

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/reset entry sequencer: arbitrates RES/NMI/IRQ/BRK, runs the
// six-cycle push/vector-fetch sequence and drives the vector address.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter int          N_IRQ        = 1,
  parameter int          NMI_SYNC     = 2,
  parameter logic [15:0] IRQ_VEC_BASE = 16'hFFF8
) (
  input  logic             PHI0,
  input  logic             _RES,
  input  logic             _NMI,
  input  logic [N_IRQ-1:0] _IRQ,
  input  logic [N_IRQ-1:0] IRQ_EN,
  input  logic             I_FLAG,
  input  logic             RDY,
  input  logic             T0,
  input  logic             BRK_OP,
  output logic             SEQ_ACTIVE,
  output logic             BRK5,
  output logic             BRK6E,
  output logic             PUSH_EN,
  output logic             RES_ACTIVE,
  output logic             B_FLAG,
  output logic [15:0]      VEC_ADDR,
  output logic [N_IRQ-1:0] IRQ_ACK
);

  logic [2:0]       state_reg, state_next;
  src_t             src_reg, src_next;
  logic [2:0]       ch_reg, ch_next;
  logic             b_reg, b_next;
  logic             res_pend_reg, res_pend_next;
  logic             nmi_pend_reg;
  logic             nmi_fall;
  logic [N_IRQ-1:0] irq_req;
  logic             irq_any;
  logic [2:0]       irq_low;
  logic             any_req;
  logic             seq_done;
  logic             hijack_window;
  logic [15:0]      vec_base;

  nmi_edge_sync #(.STAGES(NMI_SYNC)) u_nmi_sync (
    .clk      (PHI0),
    .rst_n    (_RES),
    .nmi_n    (_NMI),
    .nmi_fall (nmi_fall)
  );

  assign irq_req = ~_IRQ & IRQ_EN;
  assign irq_any = (|irq_req) & ~I_FLAG;

  always_comb begin
    irq_low = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) irq_low = 3'(i);
    end
  end

  assign any_req       = res_pend_reg | nmi_pend_reg | irq_any | BRK_OP;
  assign seq_done      = RDY && (state_reg == C6);
  assign hijack_window = (state_reg >= C1) && (state_reg <= C4);

  always_comb begin
    state_next    = state_reg;
    src_next      = src_reg;
    ch_next       = ch_reg;
    b_next        = b_reg;
    res_pend_next = res_pend_reg;
    if (RDY) begin
      case (state_reg)
        IDLE: begin
          // A pending reset starts without waiting for an instruction boundary.
          if (res_pend_reg || (T0 && any_req)) begin
            state_next = C1;
            ch_next    = 3'd0;
            b_next     = 1'b0;
            if (res_pend_reg)      src_next = SRC_RES;
            else if (nmi_pend_reg) src_next = SRC_NMI;
            else if (irq_any) begin
              src_next = SRC_IRQ;
              ch_next  = irq_low;
            end else begin
              src_next = SRC_BRK;
              b_next   = 1'b1;
            end
          end
        end
        C6: begin
          state_next = IDLE;
          b_next     = 1'b0;
          if (src_reg == SRC_RES) res_pend_next = 1'b0;
        end
        default: state_next = state_reg + 3'd1;
      endcase
      // NMI arriving before the vector fetch steals the IRQ/BRK sequence; B is kept.
      if (hijack_window && (src_reg == SRC_IRQ || src_reg == SRC_BRK) &&
          (nmi_pend_reg || nmi_fall))
        src_next = SRC_NMI;
    end
  end

  always_ff @(posedge PHI0 or negedge _RES) begin
    if (!_RES) begin
      state_reg    <= IDLE;
      src_reg      <= SRC_RES;
      ch_reg       <= 3'd0;
      b_reg        <= 1'b0;
      res_pend_reg <= 1'b1;
      nmi_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      src_reg      <= src_next;
      ch_reg       <= ch_next;
      b_reg        <= b_next;
      res_pend_reg <= res_pend_next;
      // Edge capture is not stalled by RDY so a short NMI is never lost; set wins over clear.
      nmi_pend_reg <= nmi_fall | (nmi_pend_reg & ~(seq_done && src_reg == SRC_NMI));
    end
  end

  always_comb begin
    case (src_reg)
      SRC_RES: vec_base = VEC_RES;
      SRC_NMI: vec_base = VEC_NMI;
      SRC_IRQ: vec_base = irq_vector(IRQ_VEC_BASE, ch_reg);
      default: vec_base = VEC_IRQ0;
    endcase
  end

  assign SEQ_ACTIVE = (state_reg != IDLE);
  assign BRK5       = (state_reg == C5);
  assign BRK6E      = (state_reg == C6);
  assign RES_ACTIVE = SEQ_ACTIVE && (src_reg == SRC_RES);
  assign PUSH_EN    = (state_reg >= C2) && (state_reg <= C4) && !RES_ACTIVE;
  assign B_FLAG     = b_reg;
  assign VEC_ADDR   = BRK5  ? vec_base :
                      BRK6E ? (vec_base | 16'h0001) : 16'h0000;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_ack
      assign IRQ_ACK[gi] = seq_done && (src_reg == SRC_IRQ) && (ch_reg == 3'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer (4 IRQ channels); expected sequences are
// queued when stimulus is driven and checked cycle by cycle as the DUT runs them.
module tb_int_sequencer;

  logic        PHI0 = 1'b0;
  logic        res_n = 1'b1;
  logic        nmi_n = 1'b1;
  logic [3:0]  irq_n = 4'b1111;
  logic [3:0]  irq_en = 4'b1111;
  logic        i_flag = 1'b0;
  logic        rdy = 1'b1;
  logic        t0 = 1'b0;
  logic        brk_op = 1'b0;
  logic        SEQ_ACTIVE, BRK5, BRK6E, PUSH_EN, RES_ACTIVE, B_FLAG;
  logic [15:0] VEC_ADDR;
  logic [3:0]  IRQ_ACK;

  typedef struct {
    logic [15:0] vec;
    logic [3:0]  ack;
    logic        b;
    logic        res;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  int_sequencer #(.N_IRQ(4), .NMI_SYNC(2), .IRQ_VEC_BASE(16'hFFF8)) dut (
    .PHI0       (PHI0),
    ._RES       (res_n),
    ._NMI       (nmi_n),
    ._IRQ       (irq_n),
    .IRQ_EN     (irq_en),
    .I_FLAG     (i_flag),
    .RDY        (rdy),
    .T0         (t0),
    .BRK_OP     (brk_op),
    .SEQ_ACTIVE (SEQ_ACTIVE),
    .BRK5       (BRK5),
    .BRK6E      (BRK6E),
    .PUSH_EN    (PUSH_EN),
    .RES_ACTIVE (RES_ACTIVE),
    .B_FLAG     (B_FLAG),
    .VEC_ADDR   (VEC_ADDR),
    .IRQ_ACK    (IRQ_ACK)
  );

  always #5 PHI0 = ~PHI0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] vec, input logic [3:0] ack,
                              input logic b, input logic res);
    exp_t e;
    e.vec = vec; e.ack = ack; e.b = b; e.res = res;
    return e;
  endfunction

  task automatic check_cycle(input int c, input exp_t e);
    logic [15:0] vexp;
    vexp = (c == 5) ? e.vec : (c == 6) ? (e.vec | 16'h0001) : 16'h0000;
    chk($sformatf("active_c%0d", c), 16'(SEQ_ACTIVE), 16'(1'b1));
    chk($sformatf("brk5_c%0d", c), 16'(BRK5), 16'(c == 5));
    chk($sformatf("brk6e_c%0d", c), 16'(BRK6E), 16'(c == 6));
    chk($sformatf("push_c%0d", c), 16'(PUSH_EN), 16'((c >= 2) && (c <= 4) && !e.res));
    chk($sformatf("res_active_c%0d", c), 16'(RES_ACTIVE), 16'(e.res));
    chk($sformatf("b_flag_c%0d", c), 16'(B_FLAG), 16'(e.b));
    chk($sformatf("vec_c%0d", c), VEC_ADDR, vexp);
    chk($sformatf("irq_ack_c%0d", c), 16'(IRQ_ACK), (c == 6) ? 16'(e.ack) : 16'h0000);
  endtask

  // Follows one sequence; NMI is dropped at cycle nmi_at, RDY stalled after stall_at.
  task automatic run_seq(input int nmi_at, input int stall_at, input int stall_len);
    exp_t e;
    int   waited = 0;
    int   len = 0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 16'(exp_q.size()), 16'd1);
      return;
    end
    e = exp_q.pop_front();
    do begin
      @(negedge PHI0);
      waited++;
    end while (SEQ_ACTIVE !== 1'b1 && waited < 20);
    chk("seq_start", 16'(SEQ_ACTIVE), 16'(1'b1));
    if (SEQ_ACTIVE !== 1'b1) return;
    for (int c = 1; c <= 6; c++) begin
      check_cycle(c, e);
      len++;
      if (c == 1) begin
        t0 = 1'b0;
        brk_op = 1'b0;
      end
      if (c == nmi_at) nmi_n = 1'b0;
      if (c == stall_at) begin
        rdy = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge PHI0);
          if (s == stall_len - 1) rdy = 1'b1;
          check_cycle(c, e);
          len++;
        end
      end
      @(negedge PHI0);
    end
    chk("seq_end_idle", 16'(SEQ_ACTIVE), 16'(1'b0));
    chk("seq_len", 16'(len), 16'(6 + ((stall_at > 0) ? stall_len : 0)));
    $display("seq: vec=%h ack=%b b=%0d res=%0d len=%0d", e.vec, e.ack, e.b, e.res, len);
  endtask

  task automatic expect_idle(input int n, input string tag);
    t0 = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge PHI0);
      chk(tag, 16'(SEQ_ACTIVE), 16'(1'b0));
    end
    t0 = 1'b0;
    $display("idle: %s over %0d cycles", tag, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 res_n = 1'b0;
    repeat (2) @(negedge PHI0);
    chk("rst_active", 16'(SEQ_ACTIVE), 16'd0);
    chk("rst_push", 16'(PUSH_EN), 16'd0);
    chk("rst_res_active", 16'(RES_ACTIVE), 16'd0);
    chk("rst_vec", VEC_ADDR, 16'h0000);
    chk("rst_ack", 16'(IRQ_ACK), 16'd0);
    chk("rst_b", 16'(B_FLAG), 16'd0);

    // Reset sequence after release, T0 ignored.
    exp_q.push_back(mk(16'hFFFC, 4'b0000, 1'b0, 1'b1));
    res_n = 1'b1;
    run_seq(0, 0, 0);
    expect_idle(3, "idle_after_reset");

    // ch1 and ch3 requesting: lowest index wins.
    irq_n = 4'b0101;
    exp_q.push_back(mk(16'hFFF8, 4'b0010, 1'b0, 1'b0));
    t0 = 1'b1;
    run_seq(0, 0, 0);

    // ch1 disabled: ch3 vector FFF8 - 4.
    irq_en = 4'b1101;
    exp_q.push_back(mk(16'hFFF4, 4'b1000, 1'b0, 1'b0));
    t0 = 1'b1;
    run_seq(0, 0, 0);
    irq_en = 4'b1111;

    // I flag masks every channel.
    i_flag = 1'b1;
    expect_idle(3, "i_flag_masks");
    i_flag = 1'b0;
    irq_n = 4'b1111;
    expect_idle(3, "irq_released");

    // BRK hijacked by NMI during C3: NMI vector, B still pushed as 1.
    brk_op = 1'b1;
    t0 = 1'b1;
    exp_q.push_back(mk(16'hFFFA, 4'b0000, 1'b1, 1'b0));
    run_seq(1, 0, 0);
    nmi_n = 1'b1;
    expect_idle(4, "nmi_pend_cleared");

    // NMI arriving in C5 of IRQ ch0 is too late; taken at the next T0.
    irq_n = 4'b1110;
    t0 = 1'b1;
    exp_q.push_back(mk(16'hFFFE, 4'b0001, 1'b0, 1'b0));
    run_seq(3, 0, 0);
    irq_n = 4'b1111;
    nmi_n = 1'b1;
    t0 = 1'b1;
    exp_q.push_back(mk(16'hFFFA, 4'b0000, 1'b0, 1'b0));
    run_seq(0, 0, 0);
    expect_idle(3, "idle_after_nmi");

    // BRK with a 3-cycle RDY stall in C4.
    brk_op = 1'b1;
    t0 = 1'b1;
    exp_q.push_back(mk(16'hFFFE, 4'b0000, 1'b1, 1'b0));
    run_seq(0, 4, 3);

    // Reset in C3 of an NMI sequence discards the pending NMI.
    nmi_n = 1'b0;
    repeat (4) @(negedge PHI0);
    t0 = 1'b1;
    @(negedge PHI0);
    chk("nmi_c1_active", 16'(SEQ_ACTIVE), 16'd1);
    t0 = 1'b0;
    repeat (2) @(negedge PHI0);
    chk("nmi_c3_push", 16'(PUSH_EN), 16'd1);
    #2 res_n = 1'b0;
    #1;
    chk("abort_active", 16'(SEQ_ACTIVE), 16'd0);
    chk("abort_push", 16'(PUSH_EN), 16'd0);
    chk("abort_vec", VEC_ADDR, 16'h0000);
    chk("abort_strobes", 16'({BRK5, BRK6E, RES_ACTIVE, B_FLAG}), 16'd0);
    nmi_n = 1'b1;
    @(negedge PHI0);
    exp_q.push_back(mk(16'hFFFC, 4'b0000, 1'b0, 1'b1));
    res_n = 1'b1;
    run_seq(0, 0, 0);
    expect_idle(4, "no_nmi_after_reset");

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
